odd_parity_serial_tx: RTL and testbench
=======================================

Name: odd_parity_serial_tx

Overview:
- Upstream framing stage for the odd-parity checker.
- Accepts a parallel data word over a valid/ready handshake and computes its odd parity bit, so that data ones plus P is an odd count.
- Shifts a serial frame out on one line, one bit per CLKS_PER_BIT clocks: start bit, data LSB first, parity, stop.
- The receive side deserializes the frame and presents data bits plus P to the checker.

Parameters:
- DATA_W, 3, data bits per frame (min 1).
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (min 1).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- data_in  input  DATA_W  word to transmit; sampled on accept.
- valid_in  input  1  upstream has a word.
- ready_out  output  1  block can accept a word this cycle.
- tx_out  output  1  serial line; idles high.
- par_out  output  1  odd parity of the last accepted word, held until the next accept.
- busy  output  1  frame in progress.

Behaviour:
- Reset values, applied immediately on rst_n low: state=IDLE, tx_out=1, ready_out=1, busy=0, par_out=0, shift register=0, bit counter=0, baud counter=0.
- Accept: at the rising edge where valid_in && ready_out:
  - latch data_in into the shift register;
  - set par_out = ~^data_in;
  - go to START; ready_out=0, busy=1.
- ready_out is a registered output, high only in IDLE. valid_in and data_in are ignored when ready_out=0. No combinational path exists from valid_in to ready_out.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_out=1.
  - START: tx_out=0 for CLKS_PER_BIT cycles, then DATA with bit counter=0.
  - DATA: tx_out=shift[0], held CLKS_PER_BIT cycles. Then shift right and increment the bit counter. After bit DATA_W-1, go to PARITY.
  - PARITY: tx_out=par_out for CLKS_PER_BIT cycles, then STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles, then IDLE with ready_out=1, busy=0.
- tx_out is registered. The first start-bit cycle on tx_out is the cycle after the accept edge.
- Baud counter runs 0..CLKS_PER_BIT-1 and resets to 0 on every state change. With CLKS_PER_BIT=1, each bit lasts exactly one cycle.
- Frame length is (DATA_W+3)*CLKS_PER_BIT cycles from the accept edge to ready_out going high again.
- Back-to-back frames: valid_in held high yields one accept per frame. IDLE lasts exactly one cycle between frames (tx_out=1 for that cycle plus the stop bit).
- Bit counter width is $clog2(DATA_W+1). No wrap occurs inside a frame.
- Reset mid-frame: tx_out returns to 1 immediately, the frame is abandoned, and no partial resume happens.
- The block does no error injection; parity is always correct odd parity.

Decomposition:
- Shared package parity_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - constants IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1.
  The matching receiver reuses the package.
- One natural sub-module: odd_parity_gen, a combinational ~^ reduction of DATA_W bits. The same function serves the checker-side cross-check.
- The baud counter stays inline.

Test Plan:
1. Reset release, no valid_in: tx_out=1, ready_out=1, busy=0, par_out=0 indefinitely.
2. DATA_W=3, CLKS_PER_BIT=4, send 3'b000:
   - par_out=1;
   - tx_out sequence 0,0,0,0,1,1 in 4-cycle bits;
   - ready_out high again 24 cycles after accept.
3. Send 3'b101, then 3'b111:
   - parity bits 1 then 0;
   - data emitted LSB first: 1,0,1 then 1,1,1.
4. valid_in held high with words 3'b011 and 3'b110:
   - exactly two accepts, 25 cycles apart;
   - inputs changing while busy are ignored.
5. Assert rst_n low at cycle 10 of a frame: tx_out=1 and ready_out=1 asynchronously; the next accepted word transmits a clean frame.
6. Loopback: sweep all 8 values through a deserializer into the odd-parity checker -> zero parity errors reported.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the odd-parity serial link: FSM states and line levels.
// The matching receiver imports this package as well.
package parity_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/odd_parity_serial_tx_if.sv
// Parallel word handshake between the upstream producer and the serial framer.
interface odd_parity_serial_tx_if #(
  parameter int DATA_W = 3
);

  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);

endinterface

// File: rtl/odd_parity_gen.sv
// Odd parity of a W-bit word: data ones plus the returned bit is always odd.
module odd_parity_gen #(
  parameter int W = 3
) (
  input  logic [W-1:0] data_i,
  output logic         par_o
);

  assign par_o = ~^data_i;

endmodule

// File: rtl/odd_parity_serial_tx.sv
// Serial framer: accepts a word, then sends start, data LSB first, odd parity, stop,
// each bit held CLKS_PER_BIT clocks. All outputs are registered.
module odd_parity_serial_tx
  import parity_pkg::*;
#(
  parameter int DATA_W       = 3,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  odd_parity_serial_tx_if.slave  up_if,
  output logic                   tx_out,
  output logic                   par_out,
  output logic                   busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W  = $clog2(DATA_W + 1);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  logic accept_s;
  logic bit_done_s;
  logic last_bit_s;
  logic par_gen_s;

  odd_parity_gen #(.W(DATA_W)) u_par_gen (
    .data_i (up_if.data_in),
    .par_o  (par_gen_s)
  );

  assign accept_s   = up_if.valid_in && ready_q;
  assign bit_done_s = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign last_bit_s = (bit_cnt_q == CNT_W'(DATA_W - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: every non-idle state advances only at the end of a bit time
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_s) state_d = START;  else state_d = IDLE;
      START:   if (bit_done_s) state_d = DATA; else state_d = START;
      DATA:    if (bit_done_s && last_bit_s) state_d = PARITY; else state_d = DATA;
      PARITY:  if (bit_done_s) state_d = STOP; else state_d = PARITY;
      STOP:    if (bit_done_s) state_d = IDLE; else state_d = STOP;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: baud counter, bit counter, shift register, held parity
  always_comb begin
    baud_d    = '0;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    if ((state_q != IDLE) && !bit_done_s) begin
      baud_d = baud_q + BAUD_W'(1);
    end else begin
      baud_d = '0;
    end
    if (accept_s) begin
      shift_d   = up_if.data_in;
      par_d     = par_gen_s;
      bit_cnt_d = '0;
    end else if ((state_q == START) && bit_done_s) begin
      bit_cnt_d = '0;
    end else if ((state_q == DATA) && bit_done_s) begin
      shift_d   = shift_q >> 1;
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  // Output logic: decoded from the next state so the registered line leads by no cycle
  always_comb begin
    tx_d = IDLE_LEVEL;
    case (state_d)
      IDLE:    tx_d = IDLE_LEVEL;
      START:   tx_d = START_LEVEL;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      STOP:    tx_d = STOP_LEVEL;
      default: tx_d = IDLE_LEVEL;
    endcase
    if (state_d == IDLE) begin
      ready_d = 1'b1;
      busy_d  = 1'b0;
    end else begin
      ready_d = 1'b0;
      busy_d  = 1'b1;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= IDLE_LEVEL;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign up_if.ready_out = ready_q;
  assign tx_out          = tx_q;
  assign par_out         = par_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_odd_parity_serial_tx.sv
// Directed bench for odd_parity_serial_tx with DATA_W=3, CLKS_PER_BIT=4.
module tb_odd_parity_serial_tx;

  logic clk = 1'b0;
  logic rst_n;
  logic tx_out, par_out, busy;
  int   n_checks = 0;
  int   n_errors = 0;

  odd_parity_serial_tx_if #(.DATA_W(3)) up_if ();

  odd_parity_serial_tx #(.DATA_W(3), .CLKS_PER_BIT(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .up_if   (up_if),
    .tx_out  (tx_out),
    .par_out (par_out),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge with ready high; returns at the negedge after the accept edge.
  task automatic start_frame(input logic [2:0] w, input bit hold);
    up_if.valid_in = 1'b1;
    up_if.data_in  = w;
    @(posedge clk);
    @(negedge clk);
    if (!hold) up_if.valid_in = 1'b0;
  endtask

  // frame[i] is the i-th bit on the line (start first); ends at the negedge after ready returns.
  task automatic expect_frame(input string tag, input logic [5:0] frame, input logic p,
                              input bit scramble);
    chk({tag, "_par"}, 32'(par_out), 32'(p));
    for (int j = 0; j < 24; j++) begin
      chk({tag, "_tx"}, 32'(tx_out), 32'(frame[j/4]));
      chk({tag, "_rdy_lo"}, 32'(up_if.ready_out), 32'd0);
      chk({tag, "_busy_hi"}, 32'(busy), 32'd1);
      if (scramble) up_if.data_in = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    chk({tag, "_rdy_hi"}, 32'(up_if.ready_out), 32'd1);
    chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
    chk({tag, "_idle_tx"}, 32'(tx_out), 32'd1);
    chk({tag, "_par_hold"}, 32'(par_out), 32'(p));
  endtask

  // Mid-bit sampling deserializer; returns the six line bits, start first.
  task automatic rx_frame(output logic [5:0] bits);
    bits = 6'b000000;
    for (int j = 0; j < 24; j++) begin
      if ((j % 4) == 2) bits[j/4] = tx_out;
      @(negedge clk);
    end
  endtask

  logic [2:0] vec_word  [5] = '{3'b000, 3'b101, 3'b111, 3'b011, 3'b110};
  logic [5:0] vec_frame [5] = '{6'b110000, 6'b111010, 6'b101110, 6'b110110, 6'b111100};
  logic       vec_par   [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    logic [5:0] rx_bits;
    rst_n          = 1'b1;
    up_if.valid_in = 1'b0;
    up_if.data_in  = 3'b000;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx", 32'(tx_out), 32'd1);
    chk("rst_rdy", 32'(up_if.ready_out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_par", 32'(par_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("idle_tx", 32'(tx_out), 32'd1);
      chk("idle_rdy", 32'(up_if.ready_out), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_par", 32'(par_out), 32'd0);
    end

    // Single frames: 000, 101, 111
    for (int v = 0; v < 3; v++) begin
      start_frame(vec_word[v], 1'b0);
      expect_frame($sformatf("frame%0d", v), vec_frame[v], vec_par[v], 1'b0);
      @(negedge clk);
    end

    // valid_in held high across two frames; data churns while busy
    start_frame(vec_word[3], 1'b1);
    expect_frame("b2b_a", vec_frame[3], vec_par[3], 1'b1);
    start_frame(vec_word[4], 1'b0);
    expect_frame("b2b_b", vec_frame[4], vec_par[4], 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_no_third", 32'(up_if.ready_out), 32'd1);
      chk("b2b_line_idle", 32'(tx_out), 32'd1);
      @(negedge clk);
    end

    // Reset ten cycles into a frame
    start_frame(3'b101, 1'b0);
    for (int j = 0; j < 9; j++) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx_out), 32'd1);
    chk("mid_rst_rdy", 32'(up_if.ready_out), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_par", 32'(par_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tx", 32'(tx_out), 32'd1);
    chk("post_rst_rdy", 32'(up_if.ready_out), 32'd1);
    start_frame(3'b010, 1'b0);
    expect_frame("post_rst", 6'b100100, 1'b0, 1'b0);

    // Loopback sweep through a deserializer and an odd-parity check
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      start_frame(3'(v), 1'b0);
      rx_frame(rx_bits);
      chk($sformatf("loop%0d_start", v), 32'(rx_bits[0]), 32'd0);
      chk($sformatf("loop%0d_data", v), 32'(rx_bits[3:1]), 32'(v));
      chk($sformatf("loop%0d_perr", v), 32'(^rx_bits[4:1]), 32'd1);
      chk($sformatf("loop%0d_stop", v), 32'(rx_bits[5]), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
